// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared limits, next-state table types and the elaboration-time
// KMP helpers used by seq_detector_param.
//   fail_len    : next match-progress index after (k matched bits, then b)
//   build_table : full {k, in} -> {hit, next k} table for a given pattern
package seq_det_pkg;

  localparam int unsigned PAT_W_MIN = 2;
  localparam int unsigned PAT_W_MAX = 16;
  localparam int unsigned CNT_W_MIN = 1;
  localparam int unsigned CNT_W_MAX = 32;

  // Widest progress index is $clog2(PAT_W_MAX+1); the table is sized for it.
  localparam int unsigned K_W_MAX   = 5;
  localparam int unsigned PAT_IDX_W = $clog2(PAT_W_MAX);
  localparam int unsigned TBL_IDX_W = K_W_MAX + 1;
  localparam int unsigned TBL_DEPTH = 2 ** TBL_IDX_W;

  typedef struct packed {
    logic               hit;
    logic [K_W_MAX-1:0] nxt;
  } ns_entry_t;

  typedef ns_entry_t [TBL_DEPTH-1:0] ns_table_t;

  // Longest prefix of the pattern that is a suffix of (first k pattern bits, b).
  // When k+1 == width the full pattern is excluded, giving the proper border.
  function automatic int fail_len(logic [PAT_W_MAX-1:0] pattern, int width,
                                  int k, logic b);
    int   lmax;
    int   p;
    logic ok;
    logic sb;
    lmax = (k + 1 < width) ? k + 1 : k;
    for (int l = lmax; l > 0; l--) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++) begin
        p  = k + 1 - l + j;
        sb = (p < k) ? pattern[PAT_IDX_W'(width - 1 - p)] : b;
        if (sb != pattern[PAT_IDX_W'(width - 1 - j)]) ok = 1'b0;
      end
      if (ok) return l;
    end
    return 0;
  endfunction

  // Unreachable k rows stay zero: next k = 0, no hit.
  function automatic ns_table_t build_table(logic [PAT_W_MAX-1:0] pattern,
                                            int width, bit overlap);
    ns_table_t t;
    logic      hit;
    logic      bb;
    int        nxt;
    t = '0;
    for (int k = 0; k < width; k++) begin
      for (int b = 0; b < 2; b++) begin
        bb  = (b != 0);
        hit = (k == width - 1) && (bb == pattern[0]);
        nxt = (hit && !overlap) ? 0 : fail_len(pattern, width, k, bb);
        t[TBL_IDX_W'(2 * k + b)].hit = hit;
        t[TBL_IDX_W'(2 * k + b)].nxt = K_W_MAX'(nxt);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// seq_det_sat_cnt: saturating up-counter.
//   clk, rstn : clock, async active-low reset
//   clr       : synchronous clear (priority over inc)
//   inc       : add one unless already all-ones
//   cnt       : current count
module seq_det_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised serial pattern detector with KMP fallback.
//   clk, rstn : clock, async active-low reset
//   clr       : sync clear of progress, counter and Moore output
//   in_valid  : qualifies in
//   in        : serial bit, PATTERN[PAT_W-1] expected first
//   out       : one-cycle match pulse (Mealy: same cycle, Moore: next cycle)
//   match_cnt : saturating match count
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W   = 4,
  parameter              PATTERN = 4'b1010,
  parameter bit          OVERLAP = 1'b0,
  parameter bit          MOORE   = 1'b0,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned K_W = $clog2(PAT_W + 1);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_detector_param: PAT_W out of range");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W out of range");
  end
  if ($bits(PATTERN) < PAT_W) begin : g_bad_pattern
    $error("seq_detector_param: PATTERN narrower than PAT_W");
  end

  localparam ns_table_t NS_TABLE =
    build_table(PAT_W_MAX'(PATTERN), int'(PAT_W), OVERLAP);

  logic [K_W-1:0] k;
  ns_entry_t      ent_c;
  logic           hit_c;

  // Next-state and match lookup; hit is only meaningful for accepted bits.
  always_comb begin
    ent_c = NS_TABLE[{K_W_MAX'(k), in}];
    hit_c = in_valid & ~clr & ent_c.hit;
  end

  // Match-progress index; held while in_valid is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k <= '0;
    end else if (clr) begin
      k <= '0;
    end else if (in_valid) begin
      k <= K_W'(ent_c.nxt);
    end
  end

  seq_det_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk (clk),
    .rstn(rstn),
    .clr (clr),
    .inc (hit_c),
    .cnt (match_cnt)
  );

  if (MOORE) begin : g_moore
    logic out_q;
    // hit_c is already low on clr or idle cycles, so the pulse self-clears.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        out_q <= 1'b0;
      end else begin
        out_q <= hit_c;
      end
    end
    assign out = out_q;
  end else begin : g_mealy
    assign out = hit_c;
  end

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  localparam int NI = 6;
  // Per-instance configuration, mirrored by the instances below.
  localparam int          M_PW  [NI] = '{4, 4, 4, 5, 4, 2};
  localparam logic [15:0] M_PAT [NI] = '{16'hA, 16'hA, 16'hA, 16'h1B, 16'hA, 16'h3};
  localparam bit          M_OV  [NI] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam bit          M_MO  [NI] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam int          M_CW  [NI] = '{8, 8, 8, 8, 2, 8};

  logic clk = 1'b0;
  logic rstn, clr, in_valid, in_b;
  logic [NI-1:0] outs;
  logic [7:0] c0, c1, c2, c3, c5;
  logic [1:0] c4;
  logic [31:0] cnts [NI];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_detector_param u0 (.clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid),
                         .in(in_b), .out(outs[0]), .match_cnt(c0));
  seq_detector_param #(.OVERLAP(1'b1)) u1 (.clk(clk), .rstn(rstn), .clr(clr),
                         .in_valid(in_valid), .in(in_b), .out(outs[1]), .match_cnt(c1));
  seq_detector_param #(.MOORE(1'b1)) u2 (.clk(clk), .rstn(rstn), .clr(clr),
                         .in_valid(in_valid), .in(in_b), .out(outs[2]), .match_cnt(c2));
  seq_detector_param #(.PAT_W(5), .PATTERN(5'b11011), .OVERLAP(1'b1)) u3 (.clk(clk),
                         .rstn(rstn), .clr(clr), .in_valid(in_valid), .in(in_b),
                         .out(outs[3]), .match_cnt(c3));
  seq_detector_param #(.CNT_W(2)) u4 (.clk(clk), .rstn(rstn), .clr(clr),
                         .in_valid(in_valid), .in(in_b), .out(outs[4]), .match_cnt(c4));
  seq_detector_param #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .MOORE(1'b1)) u5 (
                         .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid),
                         .in(in_b), .out(outs[5]), .match_cnt(c5));

  always_comb begin
    cnts[0] = 32'(c0);
    cnts[1] = 32'(c1);
    cnts[2] = 32'(c2);
    cnts[3] = 32'(c3);
    cnts[4] = 32'(c4);
    cnts[5] = 32'(c5);
  end

  // ---------------- model: history of accepted bits since last restart ----------------
  logic [31:0] m_hist [NI];
  int          m_len  [NI];
  logic [31:0] m_cnt  [NI];
  logic        m_mq   [NI];

  function automatic logic m_would(int i, logic b);
    logic [31:0] h;
    logic [31:0] mask;
    h    = (m_hist[i] << 1) | 32'(b);
    mask = (32'd1 << M_PW[i]) - 32'd1;
    return (m_len[i] + 1 >= M_PW[i]) && ((h & mask) == 32'(M_PAT[i]));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_hist[i] = '0;
      m_len[i]  = 0;
      m_cnt[i]  = '0;
      m_mq[i]   = 1'b0;
    end
  endtask

  always @(negedge rstn) model_reset();

  always @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < NI; i++) begin
        logic m;
        logic [31:0] cmax;
        cmax = 32'((64'd1 << M_CW[i]) - 64'd1);
        if (clr) begin
          m_hist[i] = '0;
          m_len[i]  = 0;
          m_cnt[i]  = '0;
          m_mq[i]   = 1'b0;
        end else if (in_valid) begin
          m = m_would(i, in_b);
          m_hist[i] = (m_hist[i] << 1) | 32'(in_b);
          if (m_len[i] < 32) m_len[i] = m_len[i] + 1;
          if (m) begin
            if (m_cnt[i] != cmax) m_cnt[i] = m_cnt[i] + 32'd1;
            if (!M_OV[i]) m_len[i] = 0;
          end
          m_mq[i] = m;
        end else begin
          m_mq[i] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic exp_out;
      exp_out = M_MO[i] ? m_mq[i]
                        : (rstn && !clr && in_valid && m_would(i, in_b));
      check($sformatf("u%0d.out", i), 32'(outs[i]), 32'(exp_out));
      check($sformatf("u%0d.match_cnt", i), cnts[i], m_cnt[i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic b, input logic c);
    @(posedge clk);
    #1;
    in_valid = v;
    in_b     = b;
    clr      = c;
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_clr();
    step(1'b1, 1'b1, 1'b1);
    check("clr_mealy_forced_low", 32'(outs[0] | outs[1] | outs[3] | outs[4]), 32'd0);
  endtask

  initial begin
    logic [5:0] s1, e0, e1, e2;
    logic [8:0] s2, e3, e5;
    logic [6:0] v3, d3, e3v;
    int pulses4;

    rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; in_b = 1'b0;
    model_reset();
    @(posedge clk); #3;
    check("reset_out", 32'(outs), 32'd0);
    check("reset_cnt0", cnts[0], 32'd0);
    #4 rstn = 1'b1;

    // 1010 stream: non-overlap / overlap / Moore
    s1 = 6'b101010; e0 = 6'b000100; e1 = 6'b000101; e2 = 6'b000010;
    for (int i = 5; i >= 0; i--) begin
      step(1'b1, s1[i], 1'b0);
      check("s1_out_nonovl", 32'(outs[0]), 32'(e0[i]));
      check("s1_out_ovl", 32'(outs[1]), 32'(e1[i]));
      check("s1_out_moore", 32'(outs[2]), 32'(e2[i]));
      if (i == 2) check("s1_moore_cnt_after_4th", cnts[2], 32'd0);
      if (i == 1) check("s1_moore_cnt_edge", cnts[2], 32'd1);
    end
    idle();
    check("s1_moore_single_pulse", 32'(outs[2]), 32'd0);
    check("s1_cnt_nonovl", cnts[0], 32'd1);
    check("s1_cnt_ovl", cnts[1], 32'd2);
    check("s1_cnt_moore", cnts[2], 32'd1);

    // 11011 KMP fallback, plus back-to-back 11 matches on the Moore 2-bit instance
    do_clr();
    s2 = 9'b111011011; e3 = 9'b000001001; e5 = 9'b001100100;
    for (int i = 8; i >= 0; i--) begin
      step(1'b1, s2[i], 1'b0);
      check("s2_out_11011", 32'(outs[3]), 32'(e3[i]));
      check("s2_out_11_moore", 32'(outs[5]), 32'(e5[i]));
    end
    idle();
    check("s2_out_11_last", 32'(outs[5]), 32'd1);
    check("s2_cnt_11011", cnts[3], 32'd2);
    check("s2_cnt_11", cnts[5], 32'd4);

    // in_valid gaps keep partial progress
    do_clr();
    v3 = 7'b1001101; e3v = 7'b0000001;
    d3 = {1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b1, 1'($urandom), 1'b0};
    for (int i = 6; i >= 0; i--) begin
      step(v3[i], d3[i], 1'b0);
      check("gap_out", 32'(outs[0]), 32'(e3v[i]));
    end
    idle();
    check("gap_cnt", cnts[0], 32'd1);

    // clr mid-pattern discards progress and the bit presented with it
    do_clr();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("clr_completing_bit_out", 32'(outs[0]), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("after_clr_zero_out", 32'(outs[0]), 32'd0);
    idle();
    check("after_clr_cnt", cnts[0], 32'd0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("after_clr_fresh_match", 32'(outs[0]), 32'd1);

    // saturation: eight matches on a 2-bit counter
    do_clr();
    pulses4 = 0;
    for (int n = 0; n < 8; n++) begin
      for (int j = 0; j < 4; j++) begin
        step(1'b1, (j % 2 == 0), 1'b0);
        if (outs[4]) pulses4++;
      end
    end
    idle();
    check("sat_pulses", 32'(pulses4), 32'd8);
    check("sat_cnt", cnts[4], 32'd3);
    check("sat_wide_cnt", cnts[0], 32'd8);

    // async reset mid-pattern with k = 3
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("pre_reset_pending_match", 32'(outs[0]), 32'd1);
    rstn = 1'b0;
    #1;
    check("async_reset_out", 32'(outs[0]), 32'd0);
    check("async_reset_cnt", cnts[0], 32'd0);
    check("async_reset_sat_cnt", cnts[4], 32'd0);
    #3 rstn = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    check("post_reset_no_match", 32'(outs[0]), 32'd0);
    idle();
    check("post_reset_cnt", cnts[0], 32'd0);

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector: the next generation of the fixed non-overlapping 4-bit detectors. Pattern, pattern width, overlap policy and Mealy/Moore output style are all elaboration-time parameters. Adds an input-valid qualifier, a synchronous clear and a saturating match counter. Sits on a serial bit stream (UART/SPI deserialiser side) and flags framing/sync words to downstream control.

## Interface
- PAT_W, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b1010: pattern to detect; PATTERN[PAT_W-1] is the first bit received.
- OVERLAP, 0: 1 = overlapping detection; 0 = non-overlapping detection.
- MOORE, 0: 1 = registered (Moore) output; 0 = combinational (Mealy) output.
- CNT_W, 8: match-counter width; legal range 1..32.

- clk  in  1  clock; all state is updated on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of match progress, counter and registered output; takes priority over in_valid.
- in_valid  in  1  qualifies in; when low, no state or counter change occurs.
- in  in  1  serial data bit.
- out  out  1  single-cycle match pulse.
- match_cnt  out  CNT_W  number of matches since reset or clr; saturates at all-ones.

## Operation
- The state is a match-progress index k in 0..PAT_W-1, giving the number of leading pattern bits currently matched. It is encoded in $clog2(PAT_W+1) bits.
- On each accepted bit b (in_valid=1, clr=0):
  - b == PATTERN[PAT_W-1-k] and k+1 < PAT_W: k <= k+1.
  - b mismatches: k <= length of the longest proper prefix of PATTERN that equals a suffix of (matched bits, b). This is the KMP fallback, so no partial match is lost.
  - k+1 == PAT_W with matching b: a match event fires.
    - OVERLAP=1: k <= f(PAT_W), the longest proper prefix of PATTERN that is also a suffix of it.
    - OVERLAP=0: k <= 0.
- Match event, MOORE=0: out = in_valid & ~clr & (k == PAT_W-1) & (in == PATTERN[0]), combinationally, in the same cycle as the completing bit.
- Match event, MOORE=1: out is a flop set to the match event. It is high for exactly one cycle, the cycle after the completing bit, independent of in_valid in that cycle.
- match_cnt increments by 1 on each match event and holds at 2^CNT_W-1. It is updated on the same edge that consumes the completing bit.
- in_valid=0: k, match_cnt and the Moore flop's next value are frozen, except that the Moore flop still clears after its one-cycle pulse. Partial progress survives gaps of any length.
- clr=1: k <= 0, match_cnt <= 0, Moore out flop <= 0. Mealy out is forced to 0 in that cycle. The bit presented in the clr cycle is discarded.
- Unreachable or illegal k values: next k = 0, out = 0.

## Timing
- Reset values: k = 0, match_cnt = 0, out = 0. Reset is asynchronous and may assert mid-pattern; partial progress is discarded.
- Latency, completing bit to out: 0 cycles for Mealy, 1 cycle for Moore.
- Latency, completing bit to match_cnt update: 1 clock edge.
- Throughput: one bit per cycle. Back-to-back matches are legal when OVERLAP=1 and f(PAT_W) = PAT_W-1, for example PATTERN=2'b11.
- Counter saturation coincident with a match: match_cnt stays at all-ones; out still pulses.

## Structure
- Package seq_det_pkg contains:
  - a constant function fail_len(pattern, width, k, bit) that returns the KMP next index;
  - a function that builds the full next-state table at elaboration;
  - localparam limits for PAT_W and CNT_W.
- The next-state logic is a table lookup indexed by {k, in}, generated from the package function. There are no runtime pattern comparisons beyond the table.
- One sub-module, seq_det_sat_cnt: a CNT_W saturating counter with inc and synchronous clr inputs.
- Elaboration-time assertions cover the PAT_W and CNT_W ranges and require PATTERN width ≥ PAT_W.

## Test plan
- Default parameters (1010, non-overlap, Mealy), stream 1,0,1,0,1,0 → out high only on the 4th bit; match_cnt = 1 after the stream.
- Same stream with OVERLAP=1 → out high on the 4th and 6th bits; match_cnt = 2.
- MOORE=1, OVERLAP=0, stream 1,0,1,0 then 0 → out high in the cycle after the 4th bit only, for one cycle; match_cnt = 1 on the edge consuming the 4th bit.
- PATTERN=5'b11011, PAT_W=5, OVERLAP=1, stream 1,1,1,0,1,1,0,1,1 → KMP fallback exercised; out on the 6th and 9th bits; match_cnt = 2.
- in_valid toggling 1,0,0,1,1,0,1 with data 1,x,x,0,1,x,0 (default parameters) → one match on the last accepted bit. clr applied mid-pattern (after 1,0,1), then 0 → no match; k = 0; match_cnt = 0.
- CNT_W=2, eight non-overlapping 1010 matches → match_cnt sticks at 3 while out still pulses 8 times. Assert rstn low while k = 3 → out = 0, match_cnt = 0 immediately, and the next 0 does not match.
